nes_pad_reader: RTL and testbench
=================================

# nes_pad_reader

Console-side reader for the NES controller serial protocol. It periodically or on request pulses `nes_latch`, clocks eight bits out of the controller with `nes_clk`, and samples `nes_data`. It then publishes the eight button states as a parallel, registered word for game logic. It sits directly downstream of the controller shift-register model and drives that model's latch and shift clock.

## Interface
- `HALF_PERIOD`, default 4: system clocks per half `nes_clk` period (T). Legal values are 4 and above.
- `POLL_CYCLES`, default 0: idle clocks between automatic polls. 0 disables auto-poll, so polling happens only on `start`.
- `clk`  in  1  system clock; every flop is rising-edge on this clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle poll request; honoured only in IDLE.
- `nes_data`  in  1  serial button bit from the controller, active-high (1 = pressed).
- `nes_latch`  out  1  parallel-load strobe to the controller.
- `nes_clk`  out  1  shift clock to the controller; idles low.
- `buttons`  out  8  last complete frame: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `valid`  out  1  one-cycle pulse when `buttons` updates.
- `changed`  out  1  one-cycle pulse, coincident with `valid`, when the new word differs from the previous one.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `nes_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states and transitions:
  - IDLE: latch=0, clk=0.
  - IDLE → LATCH on `start`, or when the poll counter reaches POLL_CYCLES−1 with POLL_CYCLES≠0.
  - LATCH: `nes_latch`=1 for 2T cycles, then → BIT0.
  - BIT0: latch low for T cycles. Sample into capture bit 0 on the last cycle, then → CLK_HI.
  - CLK_HI: `nes_clk`=1 for T cycles, then → CLK_LO.
  - CLK_LO: `nes_clk`=0 for T cycles. Sample into bit k (k=1..7) on the last cycle. If k=7 → UPDATE, else → CLK_HI.
  - UPDATE: one cycle, then → IDLE. Loads `buttons` from the capture register and pulses `valid`. Pulses `changed` if the new word differs from the old `buttons`.
- The bit index is a 3-bit counter and the phase counter is ⌈log2(2T)⌉ bits. The phase counter clears on every state change.
- The poll counter runs only in IDLE and clears on leaving IDLE. `start` takes priority when it coincides with poll expiry; only one frame starts.
- `start` while `busy` is ignored and not queued.
- Reset, including reset asserted mid-frame, applies immediately:
  - state=IDLE, `nes_latch`=0, `nes_clk`=0.
  - `buttons`=8'h00, `valid`=`changed`=`busy`=0.
  - Synchronizer, capture register and all counters = 0.
- An aborted frame never updates `buttons`.

## Timing
- Count from the clock edge that samples `start` as cycle 0.
  - `nes_latch` is high in cycles 1..2T.
  - Bit 0 is sampled in cycle 3T.
  - Bit k is sampled in cycle 3T+2kT.
  - `valid` is high in cycle 17T+1 only. With T=4 that is cycle 69.
- `busy` is high in cycles 1..17T+1. The earliest next `start` accepted is cycle 17T+2.
- Auto-poll frame-to-frame spacing is 17T+1+POLL_CYCLES cycles.
- The synchronizer latency is 2 cycles. T≥4 guarantees each sampled bit has been stable at the pin for at least T−2 cycles.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Shared package `nes_pkg` holds:
  - the button index constants (BTN_A=0 … BTN_R=7);
  - the state enum `nes_rd_state_t` {IDLE, LATCH, BIT0, CLK_HI, CLK_LO, UPDATE};
  - the frame length constant `NES_BITS`=8.
- One sub-module, `sync_2ff`, is the 1-bit two-flop synchronizer with the same `clk` and active-low `reset`.
- The FSM, counters and capture register live in the top module.

## Test plan
- **Single poll, T=4.** Bench controller model loads 8'b1010_0101 on latch and shifts on `nes_clk` rise; `start` pulse. Required: `nes_latch` high in cycles 1..8, `valid` high in cycle 69 only, `buttons`=8'hA5, `changed`=1.
- **Repeat identical frame.** Same stimulus polled again. Required: `valid`=1, `changed`=0, `buttons` unchanged at 8'hA5.
- **Auto-poll, POLL_CYCLES=10.** Required: `valid` pulses exactly 79 cycles apart (69+10), and `nes_clk` shows exactly 7 rising edges per frame.
- **Start while busy.** `start` again at cycle 20. Required: ignored; one `valid` at cycle 69, none after.
- **Reset mid-frame.** Assert `reset` low at cycle 30. Required: immediately `nes_latch`=`nes_clk`=0, `busy`=0, `buttons`=8'h00. After release there is no `valid` until a new `start`.
- **Simultaneous `start` and poll expiry.** Required: exactly one frame and one `valid` pulse.

Source files
------------

// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES controller reader: button bit positions,
// frame length and the reader FSM state encoding.
package nes_pkg;

    localparam int NES_BITS = 8;

    localparam int BTN_A   = 0;
    localparam int BTN_B   = 1;
    localparam int BTN_SEL = 2;
    localparam int BTN_STA = 3;
    localparam int BTN_U   = 4;
    localparam int BTN_D   = 5;
    localparam int BTN_L   = 6;
    localparam int BTN_R   = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        BIT0   = 3'd2,
        CLK_HI = 3'd3,
        CLK_LO = 3'd4,
        UPDATE = 3'd5
    } nes_rd_state_t;

    // True when a freshly captured frame differs from the published one.
    function automatic logic word_differs(input logic [NES_BITS-1:0] new_w,
                                          input logic [NES_BITS-1:0] old_w);
        return (new_w != old_w);
    endfunction

endpackage

// File: rtl/nes_pad_reader_if.sv
// Signal bundle between the pad reader, the controller pins and game logic.
// master = the reader itself, slave = everything around it.
interface nes_pad_reader_if;

    logic                          start;
    logic                          nes_data;
    logic                          nes_latch;
    logic                          nes_clk;
    logic [nes_pkg::NES_BITS-1:0]  buttons;
    logic                          valid;
    logic                          changed;
    logic                          busy;

    modport master (
        input  start,
        input  nes_data,
        output nes_latch,
        output nes_clk,
        output buttons,
        output valid,
        output changed,
        output busy
    );

    modport slave (
        output start,
        output nes_data,
        input  nes_latch,
        input  nes_clk,
        input  buttons,
        input  valid,
        input  changed,
        input  busy
    );

endinterface

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous controller data pin into
// the system clock domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift of the raw pin value; cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: latches the pad, clocks out eight bits, captures
// them and publishes a registered button word with valid/changed pulses.
// All outputs are flops fed from the current state, so each output lags the
// state register by one cycle.
module nes_pad_reader
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int POLL_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    nes_pad_reader_if.master bus
);

    localparam int PH_W   = $clog2(2 * HALF_PERIOD);
    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [PH_W-1:0]   PH_LATCH_END = PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]   PH_HALF_END  = PH_W'(HALF_PERIOD - 1);
    localparam logic [POLL_W-1:0] POLL_END     = POLL_W'((POLL_CYCLES > 0) ? (POLL_CYCLES - 1) : 0);
    localparam logic              AUTO_POLL    = (POLL_CYCLES != 0);
    localparam logic [2:0]        LAST_BIT     = 3'(NES_BITS - 1);

    nes_rd_state_t         state_q,   state_d;
    logic [PH_W-1:0]       phase_q,   phase_d;
    logic [2:0]            bit_q,     bit_d;
    logic [POLL_W-1:0]     poll_q,    poll_d;
    logic [NES_BITS-1:0]   capture_q, capture_d;
    logic [NES_BITS-1:0]   buttons_q, buttons_d;
    logic                  latch_q,   latch_d;
    logic                  nclk_q,    nclk_d;
    logic                  valid_q,   valid_d;
    logic                  changed_q, changed_d;
    logic                  busy_q,    busy_d;
    logic                  data_sync_s;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.nes_data),
        .q_o   (data_sync_s)
    );

    // Next-state, counter, capture and output-register inputs.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 1'b1;
        bit_d     = bit_q;
        poll_d    = '0;
        capture_d = capture_q;
        buttons_d = buttons_q;
        latch_d   = 1'b0;
        nclk_d    = 1'b0;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        busy_d    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                phase_d = '0;
                bit_d   = 3'd0;
                // start wins over a coincident poll expiry; both lead to the
                // same single frame.
                if (bus.start) begin
                    state_d = LATCH;
                end else if (AUTO_POLL && (poll_q == POLL_END)) begin
                    state_d = LATCH;
                end else if (AUTO_POLL) begin
                    poll_d = poll_q + 1'b1;
                end else begin
                    poll_d = '0;
                end
            end
            LATCH: begin
                latch_d = 1'b1;
                if (phase_q == PH_LATCH_END) begin
                    state_d = BIT0;
                    phase_d = '0;
                end else begin
                    state_d = LATCH;
                end
            end
            BIT0: begin
                if (phase_q == PH_HALF_END) begin
                    capture_d[0] = data_sync_s;
                    bit_d        = 3'd1;
                    state_d      = CLK_HI;
                    phase_d      = '0;
                end else begin
                    state_d = BIT0;
                end
            end
            CLK_HI: begin
                nclk_d = 1'b1;
                if (phase_q == PH_HALF_END) begin
                    state_d = CLK_LO;
                    phase_d = '0;
                end else begin
                    state_d = CLK_HI;
                end
            end
            CLK_LO: begin
                if (phase_q == PH_HALF_END) begin
                    capture_d[bit_q] = data_sync_s;
                    phase_d          = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = UPDATE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = CLK_HI;
                    end
                end else begin
                    state_d = CLK_LO;
                end
            end
            UPDATE: begin
                buttons_d = capture_q;
                valid_d   = 1'b1;
                changed_d = word_differs(capture_q, buttons_q);
                state_d   = IDLE;
                phase_d   = '0;
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // State, counters, capture register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= 3'd0;
            poll_q    <= '0;
            capture_q <= '0;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            poll_q    <= poll_d;
            capture_q <= capture_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            nclk_q    <= nclk_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.nes_latch = latch_q;
    assign bus.nes_clk   = nclk_q;
    assign bus.buttons   = buttons_q;
    assign bus.valid     = valid_q;
    assign bus.changed   = changed_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader: one instance polled on request, one
// auto-polling instance, each fed by a shift-register controller model.
module tb_nes_pad_reader;

    typedef struct packed {
        logic [7:0] btn;
        logic       chg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    nes_pad_reader_if bus_a ();
    nes_pad_reader_if bus_b ();

    nes_pad_reader #(.HALF_PERIOD(4), .POLL_CYCLES(0)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    nes_pad_reader #(.HALF_PERIOD(4), .POLL_CYCLES(10)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller models: parallel load while latch is high, shift on nes_clk rise.
    logic [7:0] pat_a = 8'h00;
    logic [7:0] sh_a = 8'h00;
    logic [7:0] sh_b = 8'h00;
    logic       a_prev = 1'b0;
    logic       b_prev = 1'b0;

    always @(posedge clk) begin
        a_prev <= bus_a.nes_clk;
        if (bus_a.nes_latch)                  sh_a <= pat_a;
        else if (bus_a.nes_clk && !a_prev)    sh_a <= {1'b0, sh_a[7:1]};
    end

    always @(posedge clk) begin
        b_prev <= bus_b.nes_clk;
        if (bus_b.nes_latch)                  sh_b <= 8'h5A;
        else if (bus_b.nes_clk && !b_prev)    sh_b <= {1'b0, sh_b[7:1]};
    end

    assign bus_a.nes_data = sh_a[0];
    assign bus_b.nes_data = sh_b[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard for instance A.
    exp_t sb_a[$];
    int   nvalid_a = 0;
    int   va_cyc = 0;

    always @(negedge clk) begin
        if (bus_a.valid) begin
            exp_t e;
            nvalid_a++;
            va_cyc = cyc;
            chk("a_valid_expected", 32'(sb_a.size() > 0), 32'd1);
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                chk("a_buttons", 32'(bus_a.buttons), 32'(e.btn));
                chk("a_changed", 32'(bus_a.changed), 32'(e.chg));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.valid) chk("b_buttons", 32'(bus_b.buttons), 32'h5A);
    end

    int t0_a = 0;
    int first_l, last_l;
    logic busy1, busy69, busy70;

    task automatic start_a(input logic [7:0] pat, input logic chg, input bit expect_done);
        exp_t e;
        pat_a = pat;
        @(negedge clk);
        bus_a.start = 1'b1;
        if (expect_done) begin
            e.btn = pat;
            e.chg = chg;
            sb_a.push_back(e);
        end
        @(negedge clk);
        bus_a.start = 1'b0;
        t0_a = cyc;
    endtask

    task automatic watch_a(input int ncyc, input int restart_at, input int reset_at);
        first_l = -1;
        last_l  = -1;
        for (int i = 0; i < ncyc; i++) begin
            int n;
            n = cyc - t0_a;
            if (bus_a.nes_latch) begin
                if (first_l < 0) first_l = n;
                last_l = n;
            end
            if (n == 1)  busy1  = bus_a.busy;
            if (n == 69) busy69 = bus_a.busy;
            if (n == 70) busy70 = bus_a.busy;
            bus_a.start = (n == restart_at - 1);
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_latch",   32'(bus_a.nes_latch), 32'd0);
                chk("rst_mid_nesclk",  32'(bus_a.nes_clk),   32'd0);
                chk("rst_mid_busy",    32'(bus_a.busy),      32'd0);
                chk("rst_mid_buttons", 32'(bus_a.buttons),   32'h00);
            end
            @(negedge clk);
        end
        bus_a.start = 1'b0;
    endtask

    task automatic wait_valid_b(input int limit, output int vcyc, output int rises, output bit ok);
        logic prev;
        prev  = bus_b.nes_clk;
        rises = 0;
        ok    = 1'b0;
        vcyc  = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (bus_b.nes_clk && !prev) rises++;
            prev = bus_b.nes_clk;
            if (bus_b.valid) begin
                ok   = 1'b1;
                vcyc = cyc;
            end
        end
    endtask

    initial begin
        int  base;
        int  v1, v2, v3, v4, r;
        bit  ok;

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_latch",   32'(bus_a.nes_latch), 32'd0);
        chk("rst_nesclk",  32'(bus_a.nes_clk),   32'd0);
        chk("rst_buttons", 32'(bus_a.buttons),   32'h00);
        chk("rst_valid",   32'(bus_a.valid),     32'd0);
        chk("rst_busy",    32'(bus_b.busy),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single poll of 8'hA5.
        base = nvalid_a;
        start_a(8'hA5, 1'b1, 1'b1);
        watch_a(80, -100, -100);
        chk("f1_latch_first", 32'(first_l), 32'd1);
        chk("f1_latch_last",  32'(last_l),  32'd8);
        chk("f1_valid_cycle", 32'(va_cyc - t0_a), 32'd69);
        chk("f1_valid_count", 32'(nvalid_a - base), 32'd1);
        chk("f1_busy_c1",     32'(busy1),  32'd1);
        chk("f1_busy_c69",    32'(busy69), 32'd1);
        chk("f1_busy_c70",    32'(busy70), 32'd0);

        // Identical frame again: no change.
        base = nvalid_a;
        start_a(8'hA5, 1'b0, 1'b1);
        watch_a(80, -100, -100);
        chk("f2_valid_cycle", 32'(va_cyc - t0_a), 32'd69);
        chk("f2_valid_count", 32'(nvalid_a - base), 32'd1);
        chk("f2_buttons",     32'(bus_a.buttons), 32'hA5);

        // Different word.
        start_a(8'h3C, 1'b1, 1'b1);
        watch_a(80, -100, -100);
        chk("f3_buttons", 32'(bus_a.buttons), 32'h3C);

        // start at cycle 20 while busy is ignored.
        base = nvalid_a;
        start_a(8'h3C, 1'b0, 1'b1);
        watch_a(200, 20, -100);
        chk("busy_start_count", 32'(nvalid_a - base), 32'd1);
        chk("busy_start_cycle", 32'(va_cyc - t0_a),   32'd69);

        // Reset at cycle 30 aborts the frame.
        base = nvalid_a;
        start_a(8'hFF, 1'b0, 1'b0);
        watch_a(31, -100, 30);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_no_valid", 32'(nvalid_a - base), 32'd0);
        chk("post_rst_buttons",  32'(bus_a.buttons),   32'h00);

        // Fresh frame after reset reports a change from 8'h00.
        base = nvalid_a;
        start_a(8'hA5, 1'b1, 1'b1);
        watch_a(80, -100, -100);
        chk("f4_valid_count", 32'(nvalid_a - base), 32'd1);
        chk("f4_buttons",     32'(bus_a.buttons), 32'hA5);

        // Auto-poll spacing and shift clocks per frame.
        wait_valid_b(300, v1, r, ok);
        chk("b_first_valid", 32'(ok), 32'd1);
        wait_valid_b(120, v2, r, ok);
        chk("b_second_valid", 32'(ok), 32'd1);
        chk("b_spacing",      32'(v2 - v1), 32'd79);
        chk("b_clk_rises",    32'(r), 32'd7);

        // start coinciding with poll expiry: one frame only.
        repeat (9) @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        wait_valid_b(120, v3, r, ok);
        chk("coinc_valid",   32'(ok), 32'd1);
        chk("coinc_spacing", 32'(v3 - v2), 32'd79);
        chk("coinc_rises",   32'(r), 32'd7);
        wait_valid_b(70, v4, r, ok);
        chk("coinc_no_extra", 32'(ok), 32'd0);

        chk("a_sb_drained", 32'(sb_a.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
